// File: rtl/fim_pf_vf_route_pkg.sv
// Shared types for the PF/VF ingress steering demux: route table entry layout,
// FSM state encoding and the per-entry match rule.
package fim_pf_vf_route_pkg;

  localparam int CNT_W   = 16;
  localparam int RT_PF_W = 3;
  localparam int RT_VF_W = 11;

  typedef struct packed {
    logic               en;
    logic               vfa;
    logic [RT_VF_W-1:0] vf;
    logic [RT_PF_W-1:0] pf;
  } route_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } fsm_state_t;

  // VF number only participates in the match for VF-active traffic.
  function automatic logic route_lookup(
    input route_entry_t       e,
    input logic [RT_PF_W-1:0] pf,
    input logic [RT_VF_W-1:0] vf,
    input logic               vfa
  );
    return e.en && (e.pf == pf) && (e.vfa == vfa) && (!vfa || (e.vf == vf));
  endfunction

endpackage

// File: rtl/fim_pf_vf_skid2.sv
// Two-entry output buffer carrying {dest, sop, eop, data}; the accept signal is
// registered so nothing on the upstream side depends combinationally on pops.
module fim_pf_vf_skid2 #(
  parameter int WIDTH  = 80,
  parameter int DEST_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DEST_W-1:0] i_dest,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_pop,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DEST_W-1:0] o_dest,
  output logic              o_sop,
  output logic              o_eop,
  output logic [WIDTH-1:0]  o_data
);

  localparam int EW = DEST_W + 2 + WIDTH;

  logic [EW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          r_ready;
  logic [1:0]    w_count_next;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push & r_ready;
  assign w_pop  = i_pop & (r_count != 2'd0);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + 2'd1;
    else if (!w_push && w_pop)
      w_count_next = r_count - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_dest, i_sop, i_eop, i_data};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_next;
      // A pop while full only reopens the input one cycle later.
      r_ready <= (w_count_next != 2'd2);
    end
  end

  assign {o_dest, o_sop, o_eop, o_data} = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_ready = r_ready;

endmodule

// File: rtl/fim_pf_vf_route_demux.sv
// Ingress steering for one PF/VF crossbar input: looks up the destination on
// the SOP beat, holds it for the packet and fans beats out one-hot.
//   state   | meaning
//   ST_IDLE | between packets; next accepted beat must carry sop
//   ST_PKT  | inside a packet; beats follow the latched destination
module fim_pf_vf_route_demux
  import fim_pf_vf_route_pkg::*;
#(
  parameter int WIDTH    = 80,
  parameter int N        = 4,
  parameter int PF_W     = RT_PF_W,
  parameter int VF_W     = RT_VF_W,
  parameter int PF_LSB   = 0,
  parameter int VF_LSB   = 3,
  parameter int VFA_BIT  = 14,
  parameter int DEF_PORT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [N-1:0]         out_sop,
  output logic [N-1:0]         out_eop,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_idx,
  input  logic [PF_W+VF_W+1:0] cfg_entry,
  output logic [CNT_W-1:0]     unroute_cnt,
  output logic [CNT_W-1:0]     proto_err_cnt
);

  localparam int IDX_W = $clog2(N);

  route_entry_t     r_table [N];
  fsm_state_t       r_state;
  fsm_state_t       w_state_next;
  logic [IDX_W-1:0] r_dest;
  logic [CNT_W-1:0] r_unroute_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [PF_W-1:0]  w_pf;
  logic [VF_W-1:0]  w_vf;
  logic             w_vfa;
  logic             w_hit;
  logic [IDX_W-1:0] w_lookup_dest;
  logic             w_accept;
  logic             w_push;
  logic [IDX_W-1:0] w_push_dest;
  logic             w_unroute_inc;
  logic             w_err_inc;
  logic             w_in_ready;
  logic             w_head_valid;
  logic [IDX_W-1:0] w_head_dest;
  logic             w_head_sop;
  logic             w_head_eop;
  logic             w_pop;

  assign w_pf     = in_data[PF_LSB +: PF_W];
  assign w_vf     = in_data[VF_LSB +: VF_W];
  assign w_vfa    = in_data[VFA_BIT];
  assign w_accept = in_valid & w_in_ready;

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    w_hit         = 1'b0;
    w_lookup_dest = IDX_W'(DEF_PORT);
    for (int i = N - 1; i >= 0; i--) begin
      if (route_lookup(r_table[i], w_pf, w_vf, w_vfa)) begin
        w_hit         = 1'b1;
        w_lookup_dest = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_push        = 1'b0;
    w_push_dest   = r_dest;
    w_unroute_inc = 1'b0;
    w_err_inc     = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (in_sop) begin
            w_push        = 1'b1;
            w_push_dest   = w_lookup_dest;
            w_unroute_inc = !w_hit;
            w_state_next  = in_eop ? ST_IDLE : ST_PKT;
          end else begin
            w_err_inc = 1'b1;
          end
        end
        ST_PKT: begin
          w_push = 1'b1;
          if (in_sop) begin
            w_err_inc     = 1'b1;
            w_push_dest   = w_lookup_dest;
            w_unroute_inc = !w_hit;
          end
          if (in_eop)
            w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_dest        <= IDX_W'(DEF_PORT);
      r_unroute_cnt <= '0;
      r_err_cnt     <= '0;
      for (int i = 0; i < N; i++)
        r_table[i] <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push)
        r_dest <= w_push_dest;
      if (w_unroute_inc && (r_unroute_cnt != '1))
        r_unroute_cnt <= r_unroute_cnt + 1'b1;
      if (w_err_inc && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 1'b1;
      if (cfg_we)
        r_table[cfg_idx] <= route_entry_t'(cfg_entry);
    end
  end

  fim_pf_vf_skid2 #(
    .WIDTH  (WIDTH),
    .DEST_W (IDX_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dest  (w_push_dest),
    .i_sop   (in_sop),
    .i_eop   (in_eop),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_ready (w_in_ready),
    .o_valid (w_head_valid),
    .o_dest  (w_head_dest),
    .o_sop   (w_head_sop),
    .o_eop   (w_head_eop),
    .o_data  (out_data)
  );

  assign w_pop         = w_head_valid & out_ready[w_head_dest];
  assign out_valid     = w_head_valid ? (N'(1) << w_head_dest) : '0;
  assign out_sop       = out_valid & {N{w_head_sop}};
  assign out_eop       = out_valid & {N{w_head_eop}};
  assign in_ready      = w_in_ready;
  assign unroute_cnt   = r_unroute_cnt;
  assign proto_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_fim_pf_vf_route_demux.sv
// Directed plus randomized bench for the PF/VF route demux, checked against a
// packet-level reference model (table arrays, expected-output queue).
module tb_fim_pf_vf_route_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [79:0] out_data;
  logic [3:0]  out_sop;
  logic [3:0]  out_eop;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'hF;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_entry = '0;
  logic [15:0] unroute_cnt;
  logic [15:0] proto_err_cnt;

  fim_pf_vf_route_demux dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_entry(cfg_entry),
    .unroute_cnt(unroute_cnt), .proto_err_cnt(proto_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  dest;
    logic        sop;
    logic        eop;
    logic [79:0] data;
  } exp_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [79:0] data;
  } beat_t;

  exp_t  q[$];
  beat_t pend[$];

  logic        t_en [4];
  logic        t_vfa[4];
  logic [10:0] t_vf [4];
  logic [2:0]  t_pf [4];
  bit          m_in_pkt;
  int          m_dest;
  int          m_unroute;
  int          m_err;
  bit          rdy_hold;
  bit          gap;
  int          n_pass = 0;
  int          n_tot  = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [79:0] mk_beat(input logic [2:0] pf, input logic [10:0] vf, input logic vfa);
    logic [79:0] d;
    d = {16'($urandom), $urandom, $urandom};
    d[2:0]  = pf;
    d[13:3] = vf;
    d[14]   = vfa;
    return d;
  endfunction

  function automatic int model_route(input logic [79:0] d);
    for (int i = 0; i < 4; i++)
      if (t_en[i] && t_pf[i] == d[2:0] && t_vfa[i] == d[14] && (!d[14] || t_vf[i] == d[13:3]))
        return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    pend.delete();
    for (int i = 0; i < 4; i++) begin
      t_en[i] = 1'b0; t_vfa[i] = 1'b0; t_vf[i] = '0; t_pf[i] = '0;
    end
    m_in_pkt = 0; m_dest = 0; m_unroute = 0; m_err = 0;
  endtask

  task automatic add_pkt(input int len, input logic [2:0] pf, input logic [10:0] vf, input logic vfa);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.sop  = (k == 0);
      b.eop  = (k == len - 1);
      b.data = mk_beat(pf, vf, vfa);
      pend.push_back(b);
    end
  endtask

  // One clock: compare outputs with the model, advance the model by what the
  // handshakes of this cycle do, then step to just after the next edge.
  task automatic cycle();
    exp_t       h;
    exp_t       e;
    logic [3:0] exp_v;
    bit         exp_rdy;
    bit         acc;
    int         d;
    if (pend.size() > 0 && !gap) begin
      in_valid = 1'b1; in_sop = pend[0].sop; in_eop = pend[0].eop; in_data = pend[0].data;
    end else begin
      in_valid = 1'b0;
    end
    exp_rdy = !rdy_hold && (q.size() < 2);
    chk("in_ready", 80'(in_ready), 80'(exp_rdy));
    if (q.size() > 0) begin
      h = q[0];
      exp_v = 4'(1) << h.dest;
      chk("out_valid", 80'(out_valid), 80'(exp_v));
      chk("out_data", out_data, h.data);
      chk("out_sop", 80'(out_sop), 80'(h.sop ? exp_v : 4'b0));
      chk("out_eop", 80'(out_eop), 80'(h.eop ? exp_v : 4'b0));
    end else begin
      chk("out_valid_idle", 80'(out_valid), 80'(0));
    end
    chk("unroute_cnt", 80'(unroute_cnt), 80'(m_unroute));
    chk("proto_err_cnt", 80'(proto_err_cnt), 80'(m_err));
    acc = in_valid && exp_rdy;
    if (q.size() > 0 && out_ready[q[0].dest]) void'(q.pop_front());
    if (acc) begin
      void'(pend.pop_front());
      if (in_sop) begin
        if (m_in_pkt) m_err = (m_err < 65535) ? m_err + 1 : m_err;
        d = model_route(in_data);
        if (d < 0) begin
          d = 0;
          m_unroute = (m_unroute < 65535) ? m_unroute + 1 : m_unroute;
        end
        m_dest = d;
        e.dest = 2'(m_dest); e.sop = 1'b1; e.eop = in_eop; e.data = in_data;
        q.push_back(e);
        m_in_pkt = !in_eop;
      end else if (!m_in_pkt) begin
        m_err = (m_err < 65535) ? m_err + 1 : m_err;
      end else begin
        e.dest = 2'(m_dest); e.sop = 1'b0; e.eop = in_eop; e.data = in_data;
        q.push_back(e);
        if (in_eop) m_in_pkt = 0;
      end
    end
    if (cfg_we) begin
      t_en[cfg_idx] = cfg_entry[15]; t_vfa[cfg_idx] = cfg_entry[14];
      t_vf[cfg_idx] = cfg_entry[13:3]; t_pf[cfg_idx] = cfg_entry[2:0];
    end
    @(posedge clk);
    #1;
    rdy_hold = 0;
  endtask

  task automatic cfg_write(input int idx, input logic en, input logic vfa, input logic [10:0] vf, input logic [2:0] pf);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_entry = {en, vfa, vf, pf};
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (pend.size() > 0 || q.size() > 0); k++) cycle();
    chk("drain_left", 80'(pend.size() + q.size()), 80'(0));
  endtask

  initial begin
    beat_t b;
    model_reset();
    gap = 0;
    rdy_hold = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_out_sop", 80'(out_sop), 80'(0));
    chk("rst_out_eop", 80'(out_eop), 80'(0));
    chk("rst_out_data", out_data, 80'(0));
    chk("rst_unroute", 80'(unroute_cnt), 80'(0));
    chk("rst_proto_err", 80'(proto_err_cnt), 80'(0));
    rst = 1'b0;
    cycle();
    chk("ready_after_release", 80'(in_ready), 80'(1));

    // Mapped 4-beat packet to port 2 at full rate.
    cfg_write(2, 1'b1, 1'b1, 11'd5, 3'd1);
    add_pkt(4, 3'd1, 11'd5, 1'b1);
    cycle();
    chk("mapped_first_valid", 80'(out_valid), 80'(4'b0100));
    drain();

    // Unmapped pf=7 falls back to port 0.
    add_pkt(2, 3'd7, 11'd0, 1'b0);
    drain();
    chk("unroute_after_pf7", 80'(unroute_cnt), 80'(1));

    // Entries 1 and 3 both match; lowest index wins.
    cfg_write(1, 1'b1, 1'b0, 11'd0, 3'd4);
    cfg_write(3, 1'b1, 1'b0, 11'd0, 3'd4);
    add_pkt(1, 3'd4, 11'd77, 1'b0);
    cycle();
    chk("priority_port1", 80'(out_valid), 80'(4'b0010));
    drain();

    // Stall port 2 mid-packet while wiggling the unrelated ready bit.
    add_pkt(6, 3'd1, 11'd5, 1'b1);
    cycle();
    cycle();
    for (int k = 0; k < 5; k++) begin
      out_ready = {1'b1, 1'b0, 1'b1, 1'(k)};
      cycle();
    end
    chk("stall_in_ready", 80'(in_ready), 80'(0));
    out_ready = 4'hF;
    drain();

    // Orphan beat, then a SOP arriving inside a packet.
    b.sop = 1'b0; b.eop = 1'b1; b.data = mk_beat(3'd1, 11'd5, 1'b1);
    pend.push_back(b);
    drain();
    chk("orphan_err", 80'(proto_err_cnt), 80'(1));
    add_pkt(2, 3'd1, 11'd5, 1'b1);
    void'(pend.pop_back());
    add_pkt(2, 3'd4, 11'd0, 1'b0);
    drain();
    chk("sop_in_pkt_err", 80'(proto_err_cnt), 80'(2));

    // Rewrite entry 2 while its packet is in flight.
    add_pkt(4, 3'd1, 11'd5, 1'b1);
    cycle();
    cycle();
    cfg_write(2, 1'b1, 1'b0, 11'd0, 3'd6);
    drain();
    add_pkt(1, 3'd1, 11'd5, 1'b1);
    add_pkt(2, 3'd6, 11'd9, 1'b0);
    drain();

    // Reset in the middle of a stalled packet.
    add_pkt(4, 3'd4, 11'd0, 1'b0);
    out_ready = 4'h0;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 80'(out_valid), 80'(0));
    chk("midrst_out_data", out_data, 80'(0));
    chk("midrst_in_ready", 80'(in_ready), 80'(0));
    chk("midrst_unroute", 80'(unroute_cnt), 80'(0));
    chk("midrst_proto_err", 80'(proto_err_cnt), 80'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_hold = 1;
    out_ready = 4'hF;
    b.sop = 1'b0; b.eop = 1'b0; b.data = mk_beat(3'd4, 11'd0, 1'b0);
    pend.push_back(b);
    add_pkt(3, 3'd4, 11'd0, 1'b0);
    drain();
    chk("postrst_orphan_err", 80'(proto_err_cnt), 80'(1));

    // Randomized traffic, backpressure and table writes.
    for (int i = 0; i < 4; i++)
      cfg_write(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                11'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
    for (int c = 0; c < 600; c++) begin
      if (pend.size() == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          b.sop  = (k == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
          b.eop  = (k == len - 1);
          b.data = mk_beat(3'($urandom_range(0, 3)), 11'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          pend.push_back(b);
        end
      end
      gap = ($urandom_range(0, 3) == 0);
      out_ready = 4'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        cfg_we = 1'b1;
        cfg_idx = 2'($urandom_range(0, 3));
        cfg_entry = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     11'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      end
      cycle();
      cfg_we = 1'b0;
    end
    gap = 0;
    out_ready = 4'hF;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
